demux4_collector: RTL and testbench
===================================

DEMUX4_COLLECTOR -- requirements
Module: demux4_collector

Interface
REQ-001 Parameters SHALL be none; lane count is fixed at 4 and lane index width at 2.
REQ-002 clock  input  1  single clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  reset is asynchronous and active-low.
REQ-004 in  input  1  serial data bit to be steered into one lane.
REQ-005 valid  input  1  write strobe; one write is accepted per cycle when high.
REQ-006 control  input  2  destination lane (00->lane0, 01->lane1, 10->lane2, 11->lane3); used only when auto=0.
REQ-007 auto  input  1  1: lane taken from the internal pointer; 0: lane taken from control.
REQ-008 clear  input  1  synchronous frame clear.
REQ-009 out  output  4  captured lane bits; out[k] holds the last bit written to lane k.
REQ-010 written  output  4  per-lane written mask for the current frame.
REQ-011 full  output  1  high while written==4'b1111.
REQ-012 done  output  1  one-cycle frame-complete pulse.
REQ-013 overrun  output  1  sticky error flag.

Function
REQ-014 Lane select SHALL be lane = auto ? ptr : control, evaluated in the cycle valid is high.
REQ-015 On an accepted write (valid=1, clear=0), out[lane] SHALL take in at that edge and written[lane] SHALL become 1; all other out bits SHALL hold.
REQ-016 Write latency SHALL be one cycle: data is visible on out in the cycle after the edge that samples valid.
REQ-017 The internal 2-bit ptr SHALL increment on every accepted write with auto=1, wrapping 3->0; writes with auto=0 SHALL NOT change ptr.
REQ-018 Frame state SHALL be EMPTY (written=0), FILL (0<written<1111) or FULL (written=1111).
REQ-019 Transitions: EMPTY->FILL on any write; FILL->FULL on the write that sets the last clear bit; FILL->FILL otherwise; FULL->FILL on any write; any state->EMPTY on clear.
REQ-020 A write in FULL SHALL start a new frame: written becomes one-hot(lane), out[lane] updates, other out bits hold, and full deasserts.
REQ-021 done SHALL be high for exactly the one cycle in which the state first reads FULL, and low otherwise; it is not re-asserted while FULL holds.
REQ-022 A write in FILL to a lane whose written bit is already 1 SHALL overwrite out[lane], leave written unchanged, and set overrun; overrun stays set until clear or reset.
REQ-023 A write in FULL SHALL NOT set overrun.
REQ-024 clear SHALL have priority over valid: written<=0, out<=0, ptr<=0, full<=0, overrun<=0, done<=0; the coincident write is dropped.
REQ-025 With valid=0 and clear=0, all registers SHALL hold.

Reset
REQ-026 On reset_n=0, out=4'b0000, written=4'b0000, ptr=0, state=EMPTY, full=0, done=0, overrun=0, immediately and regardless of clock.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; after reset release the first accepted auto write SHALL go to lane0.
REQ-028 A write sampled on the first edge after reset_n deasserts SHALL be accepted normally.

Structure
REQ-029 The shared package SHALL hold the lane-index width constant (2), the lane count (4) and the EMPTY/FILL/FULL state encoding.
REQ-030 Lane decode SHALL be one sub-module, decoder4: 2-bit select plus enable in, 4-bit one-hot enable out, built from two-level 1-to-2 decode stages.
REQ-031 All flops SHALL be in demux4_collector; decoder4 SHALL be purely combinational.

Verification
REQ-032 Auto fill: reset, auto=1, valid for 4 cycles with in=1,0,1,1 -> out=4'b1101, written=1111, full=1, done pulses once in cycle 5, ptr back to 0.
REQ-033 Addressed fill: auto=0, control=3,1,0,2 with in=1,1,0,1 -> out=4'b1110, done one pulse, overrun=0.
REQ-034 Overrun: auto=0, write lane2 in=1, then lane2 in=0 -> out[2]=0, written=0100, overrun=1 and it holds through 10 idle cycles.
REQ-035 Frame restart: from FULL out=1111, write lane1 in=0 -> written=0010, out=1101, full=0, done=0, overrun=0.
REQ-036 Clear vs valid: in FILL, assert clear and valid together -> next cycle out=0000, written=0000, ptr=0, overrun=0, write dropped.
REQ-037 Async reset: assert reset_n=0 between clock edges after 2 auto writes -> outputs zero immediately; after release, next auto write lands in lane0.

Source files
------------

// File: rtl/demux4_collector_pkg.sv
// Shared constants and frame-state encoding for the 4-lane serial collector.
package demux4_collector_pkg;
  localparam int LANE_W    = 2;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2
  } frame_state_e;
endpackage

// File: rtl/demux4_collector_decoder4.sv
// 2-to-4 one-hot decoder built from two levels of 1-to-2 splits; purely combinational.
module decoder4
  import demux4_collector_pkg::*;
(
  input  logic [LANE_W-1:0]    sel_i,
  input  logic                 en_i,
  output logic [NUM_LANES-1:0] y_o
);
  logic [1:0] l1;

  assign l1 = {en_i & sel_i[1], en_i & ~sel_i[1]};

  // Each first-level branch splits again on the low select bit.
  for (genvar g = 0; g < 2; g++) begin : g_l2
    assign y_o[2*g]   = l1[g] & ~sel_i[0];
    assign y_o[2*g+1] = l1[g] &  sel_i[0];
  end
endmodule

// File: rtl/demux4_collector.sv
// Steers a serial bit into one of four lanes and tracks frame completion per lane.
module demux4_collector
  import demux4_collector_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in,
  input  logic                 valid,
  input  logic [LANE_W-1:0]    control,
  input  logic                 auto,
  input  logic                 clear,
  output logic [NUM_LANES-1:0] out,
  output logic [NUM_LANES-1:0] written,
  output logic                 full,
  output logic                 done,
  output logic                 overrun
);
  frame_state_e         state_q;
  logic [NUM_LANES-1:0] out_q, written_q, wr_oh, written_d;
  logic [LANE_W-1:0]    ptr_q, lane;
  logic                 full_q, done_q, overrun_q;

  assign lane = auto ? ptr_q : control;

  decoder4 u_dec (
    .sel_i (lane),
    .en_i  (valid & ~clear),
    .y_o   (wr_oh)
  );

  assign written_d = written_q | wr_oh;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_EMPTY;
      out_q     <= '0;
      written_q <= '0;
      ptr_q     <= '0;
      full_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        state_q   <= ST_EMPTY;
        out_q     <= '0;
        written_q <= '0;
        ptr_q     <= '0;
        full_q    <= 1'b0;
        overrun_q <= 1'b0;
      end else if (valid) begin
        out_q <= (out_q & ~wr_oh) | ({NUM_LANES{in}} & wr_oh);
        if (auto) ptr_q <= ptr_q + 1'b1;
        case (state_q)
          ST_EMPTY: begin
            written_q <= wr_oh;
            state_q   <= ST_FILL;
          end
          ST_FILL: begin
            written_q <= written_d;
            if (|(written_q & wr_oh)) overrun_q <= 1'b1;
            if (&written_d) begin
              state_q <= ST_FULL;
              full_q  <= 1'b1;
              done_q  <= 1'b1;
            end
          end
          ST_FULL: begin
            // A write into a complete frame opens the next one.
            written_q <= wr_oh;
            state_q   <= ST_FILL;
            full_q    <= 1'b0;
          end
          default: state_q <= ST_EMPTY;
        endcase
      end
    end
  end

  assign out     = out_q;
  assign written = written_q;
  assign full    = full_q;
  assign done    = done_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_demux4_collector.sv
// Scoreboard bench: directed scenarios then random traffic against a lane-array reference model.
module tb_demux4_collector;
  logic       clock = 1'b0;
  logic       reset_n, in, valid, auto, clear;
  logic [1:0] control;
  logic [3:0] out, written;
  logic       full, done, overrun;

  demux4_collector dut (
    .clock(clock), .reset_n(reset_n), .in(in), .valid(valid), .control(control),
    .auto(auto), .clear(clear), .out(out), .written(written), .full(full),
    .done(done), .overrun(overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] o;
    logic [3:0] w;
    logic       f, d, ov;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0, checks = 0, cycle_no = 0;

  // Reference model: per-lane value and written flag, pointer as an integer.
  bit m_val[4];
  bit m_wr[4];
  int m_ptr;
  bit m_done, m_ovr;

  function automatic bit m_all();
    return m_wr[0] && m_wr[1] && m_wr[2] && m_wr[3];
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < 4; k++) begin m_val[k] = 0; m_wr[k] = 0; end
    m_ptr = 0; m_done = 0; m_ovr = 0;
  endfunction

  function automatic void m_step();
    int ln;
    m_done = 0;
    if (!reset_n || clear) begin
      m_reset();
    end else if (valid) begin
      ln = auto ? m_ptr : int'(control);
      if (auto) m_ptr = (m_ptr + 1) % 4;
      if (m_all()) begin
        for (int k = 0; k < 4; k++) m_wr[k] = 0;
      end else if (m_wr[ln]) begin
        m_ovr = 1;
      end
      m_wr[ln]  = 1;
      m_val[ln] = in;
      m_done    = m_all();
    end
  endfunction

  function automatic exp_t m_snap();
    exp_t e;
    for (int k = 0; k < 4; k++) begin e.o[k] = m_val[k]; e.w[k] = m_wr[k]; end
    e.f = m_all(); e.d = m_done; e.ov = m_ovr; e.cyc = cycle_no;
    return e;
  endfunction

  task automatic cyc(input logic v, input logic i, input logic a, input logic c,
                     input logic [1:0] ctl);
    valid = v; in = i; auto = a; clear = c; control = ctl;
    @(posedge clock);
    cycle_no++;
    m_step();
    exp_q.push_back(m_snap());
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 2'd0);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (out !== 4'b0 || written !== 4'b0 || full !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL %s: out=%b written=%b full=%b done=%b overrun=%b, required all zero",
               name, out, written, full, done, overrun);
    end
  endtask

  // Monitor: outputs are registered, so each cycle's result is stable at the negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (out !== e.o || written !== e.w || full !== e.f || done !== e.d || overrun !== e.ov) begin
          errors++;
          $display("FAIL cycle%0d: got out=%b wr=%b full=%b done=%b ovr=%b, required out=%b wr=%b full=%b done=%b ovr=%b",
                   e.cyc, out, written, full, done, overrun, e.o, e.w, e.f, e.d, e.ov);
        end
      end
    end
  end

  initial begin
    m_reset();
    reset_n = 1'b0; valid = 0; in = 0; auto = 0; clear = 0; control = 2'd0;
    #3 check_zero("reset_state");
    @(negedge clock);
    idle(1);
    reset_n = 1'b1;

    // Auto fill 1,0,1,1 -> out 1101, done once, then hold
    cyc(1, 1, 1, 0, 0); cyc(1, 0, 1, 0, 0); cyc(1, 1, 1, 0, 0); cyc(1, 1, 1, 0, 0);
    idle(3);
    // pointer wrapped: next auto write must land in lane0
    cyc(1, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);

    // Addressed fill lanes 3,1,0,2
    cyc(1, 1, 0, 0, 3); cyc(1, 1, 0, 0, 1); cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 2);
    idle(2);
    cyc(0, 0, 0, 1, 0);

    // Overrun on lane2, held through idle
    cyc(1, 1, 0, 0, 2); cyc(1, 0, 0, 0, 2);
    idle(10);
    cyc(0, 0, 0, 1, 0);

    // Frame restart from FULL 1111 with a write of 0 to lane1
    for (int k = 0; k < 4; k++) cyc(1, 1, 0, 0, 2'(k));
    cyc(1, 0, 0, 0, 1);
    idle(1);

    // Clear together with valid in FILL: write dropped
    cyc(1, 1, 0, 0, 3);
    cyc(1, 1, 1, 1, 0);
    cyc(1, 1, 1, 0, 2);
    cyc(0, 0, 0, 1, 0);

    // Async reset between edges after two auto writes
    cyc(1, 1, 1, 0, 0); cyc(1, 1, 1, 0, 0);
    #2 reset_n = 1'b0;
    #1 check_zero("async_reset");
    m_reset();
    @(negedge clock);
    idle(2);
    reset_n = 1'b1;
    cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);

    // Random traffic
    for (int n = 0; n < 400; n++)
      cyc($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom),
          $urandom_range(0, 29) == 0, 2'($urandom));

    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end
endmodule
